// File: rtl/q3a_window_counter.sv
// ---------------------------------------------------------------------------
// q3a_window_counter
//
// Window-match FSM. After a start request it chops the w stream into
// back-to-back windows of WIN cycles, counts the ones in each window and
// pulses z when that count satisfies the compare rule selected by MODE
// against TARGET (0: ==, 1: >=, 2: <=).
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   s         start request, only looked at while idle
//   w         data bit, only looked at while running
//   stop      abort, only looked at while running; drops the partial window
//   z         one-cycle match pulse, aligned with win_done
//   win_done  one-cycle window-complete pulse
//   win_cnt   ones count of the last completed window, held between windows
//   active    high while running
// ---------------------------------------------------------------------------
module q3a_window_counter #(
    parameter int WIN    = 3,
    parameter int TARGET = 2,
    parameter int MODE   = 0,
    localparam int CW    = $clog2(WIN + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s,
    input  logic          w,
    input  logic          stop,
    output logic          z,
    output logic          win_done,
    output logic [CW-1:0] win_cnt,
    output logic          active
);

    // Reject parameter combinations that make the compare meaningless.
    generate
        if (WIN < 1 || WIN > 255 || TARGET < 0 || TARGET > WIN || MODE < 0 || MODE > 2) begin : g_bad_params
            $error("q3a_window_counter: illegal WIN/TARGET/MODE combination");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e        state_q;
    logic [CW-1:0] phase_q;
    logic [CW-1:0] acc_q;
    logic [CW-1:0] winCnt_q;
    logic          z_q;
    logic          winDone_q;

    logic [CW-1:0] total_d;
    logic          match_d;
    logic          lastBit_d;

    // Running count including the bit sampled on this edge; it cannot exceed
    // WIN, so CW bits are always enough.
    always_comb begin
        total_d   = acc_q + CW'(w);
        lastBit_d = (phase_q == CW'(WIN - 1));
        match_d   = 1'b0;
        case (MODE)
            0:       match_d = (total_d == CW'(TARGET));
            1:       match_d = (total_d >= CW'(TARGET));
            2:       match_d = (total_d <= CW'(TARGET));
            default: match_d = 1'b0;
        endcase
    end

    // Single state machine: pulses default low every edge and are raised only
    // on the edge that samples a window's last bit. stop takes priority over
    // closing a window, so an aborted last bit produces no pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            acc_q     <= '0;
            winCnt_q  <= '0;
            z_q       <= 1'b0;
            winDone_q <= 1'b0;
        end else begin
            z_q       <= 1'b0;
            winDone_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (s) begin
                        state_q <= RUN;
                        phase_q <= '0;
                        acc_q   <= '0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_q <= IDLE;
                        phase_q <= '0;
                        acc_q   <= '0;
                    end else if (lastBit_d) begin
                        winCnt_q  <= total_d;
                        winDone_q <= 1'b1;
                        z_q       <= match_d;
                        acc_q     <= '0;
                        phase_q   <= '0;
                    end else begin
                        acc_q   <= total_d;
                        phase_q <= phase_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    phase_q <= '0;
                    acc_q   <= '0;
                end
            endcase
        end
    end

    assign z        = z_q;
    assign win_done = winDone_q;
    assign win_cnt  = winCnt_q;
    assign active   = (state_q == RUN);

endmodule
